sync_fifo_mc: RTL

Multi-channel synchronous FIFO: NUM_CH independent circular queues share one memory array of NUM_CH*CH_DEPTH words. It is the parametrised successor of the single-queue FIFO memory, used where several producer/consumer streams in one clock domain each need a FIFO. It adds per-channel pointers, full/empty/count status, a registered read port and optional sticky error flags.

---
 rtl/sync_fifo_mc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_mc.sv
// rtl/sync_fifo_mc.sv - multi-channel synchronous FIFO sharing one memory array
//
// NUM_CH independent circular queues, each CH_DEPTH words, stored in a single
// NUM_CH*CH_DEPTH word memory. Channel k owns words k*CH_DEPTH .. k*CH_DEPTH+CH_DEPTH-1.
// One write and one read can be accepted every cycle, on any channels.
//
// Optional feature macro: SYNC_FIFO_MC_ERR_EN
//   defined     : wr_err / rd_err are sticky flags set by any rejected request
//   not defined : wr_err / rd_err are tied to 0
//
// Ports:
//   clk       clock, all logic on rising edge
//   reset_n   asynchronous active-low reset
//   wr_en     write request
//   wr_ch     write channel
//   wr_data   write data
//   rd_en     read request
//   rd_ch     read channel
//   rd_data   read data, registered, holds between accepted reads
//   rd_valid  rd_data was updated by the most recent edge
//   full      per-channel full
//   empty     per-channel empty
//   count     per-channel occupancy, channel k at [k*(CH_AW+1) +: CH_AW+1]
//   wr_err    sticky write-rejected flag
//   rd_err    sticky read-rejected flag

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sync_fifo_mc #(
   parameter  int NUM_CH     = 4,
   parameter  int CH_DEPTH   = `FIFO_DEPTH,
   parameter  int DATA_WIDTH = `DATA_WIDTH,
   localparam int CH_AW      = $clog2(CH_DEPTH),
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        wr_en,
   input  logic [CH_W-1:0]             wr_ch,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        rd_en,
   input  logic [CH_W-1:0]             rd_ch,
   output logic [DATA_WIDTH-1:0]       rd_data,
   output logic                        rd_valid,
   output logic [NUM_CH-1:0]           full,
   output logic [NUM_CH-1:0]           empty,
   output logic [NUM_CH*(CH_AW+1)-1:0] count,
   output logic                        wr_err,
   output logic                        rd_err
);

   localparam int             CW       = CH_AW + 1;
   localparam logic [CH_W:0]  NUM_CH_V = (CH_W + 1)'(NUM_CH);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [CH_AW:0]          wptr [NUM_CH];
   logic [CH_AW:0]          rptr [NUM_CH];
   logic [DATA_WIDTH-1:0]   mem  [NUM_CH*CH_DEPTH];

   logic                    wr_ch_ok;
   logic                    rd_ch_ok;
   logic                    wr_ok;
   logic                    rd_ok;
   logic [CH_W+CH_AW-1:0]   waddr;
   logic [CH_W+CH_AW-1:0]   raddr;

   // Status is decoded from registered pointers only.
   always_comb begin
      empty = '0;
      full  = '0;
      count = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         empty[k]          = (wptr[k] == rptr[k]);
         full[k]           = (wptr[k][CH_AW] != rptr[k][CH_AW]) &&
                             (wptr[k][CH_AW-1:0] == rptr[k][CH_AW-1:0]);
         count[k*CW +: CW] = wptr[k] - rptr[k];
      end
   end

   // Acceptance looks at the flags from the start of the cycle, so a same-cycle
   // write never makes an empty channel readable and a same-cycle read never
   // frees room in a full channel.
   assign wr_ch_ok = ({1'b0, wr_ch} < NUM_CH_V);
   assign rd_ch_ok = ({1'b0, rd_ch} < NUM_CH_V);
   assign wr_ok    = wr_en && wr_ch_ok && !full[wr_ch];
   assign rd_ok    = rd_en && rd_ch_ok && !empty[rd_ch];

   // Channel region base is ch*CH_DEPTH; with CH_DEPTH a power of two this is
   // just the channel number above the in-channel offset.
   assign waddr = {wr_ch, wptr[wr_ch][CH_AW-1:0]};
   assign raddr = {rd_ch, rptr[rd_ch][CH_AW-1:0]};

   // Storage is not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[waddr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            wptr[k] <= '0;
            rptr[k] <= '0;
         end
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_ok && (int'(wr_ch) == k)) begin
               wptr[k] <= wptr[k] + 1'b1;
            end
            if (rd_ok && (int'(rd_ch) == k)) begin
               rptr[k] <= rptr[k] + 1'b1;
            end
         end
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data <= mem[raddr];
         end
      end
   end

`ifdef SYNC_FIFO_MC_ERR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_err <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         if (wr_en && !wr_ok) begin
            wr_err <= 1'b1;
         end
         if (rd_en && !rd_ok) begin
            rd_err <= 1'b1;
         end
      end
   end
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

endmodule
